stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- 1-to-N demultiplexer for valid/ready streams; the routing counterpart to the N-to-1 mux.
- Steers each input beat to one of NUM_OUTPUT output channels chosen by a per-beat select.
- Each channel has a one-entry registered output slot, so a stalled channel back-pressures only beats addressed to it.
- Sits between a single producer (e.g. a shared decoder) and several per-channel consumers.

Parameters:
- DATA_WIDTH, 16, bit width of data on input and every output.
- NUM_OUTPUT, 8, number of output channels; any value >= 2, non-power-of-2 allowed.
- NUM_OUTPUT_BITWIDTH, $clog2(NUM_OUTPUT), derived select width; not overridden.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  input beat valid.
- o_ready  output  1  input beat accepted when i_valid & o_ready.
- i_data  input  DATA_WIDTH  input beat payload.
- i_sel  input  NUM_OUTPUT_BITWIDTH  destination channel index.
- i_last  input  1  end-of-packet marker; used only with the optional feature.
- o_valid  output  NUM_OUTPUT  per-channel output valid.
- i_ready  input  NUM_OUTPUT  per-channel consumer ready.
- o_data  output  DATA_WIDTH x [NUM_OUTPUT]  unpacked array, per-channel payload.
- o_err  output  1  one-cycle pulse when an out-of-range beat is dropped.

Behaviour:
- Reset (async assert, sync release): o_valid all 0, o_data all 0, o_err 0, lock state IDLE.
- Latency: an accepted beat appears on o_valid[sel]/o_data[sel] the next cycle. Throughput is 1 beat/cycle per channel.
- Slot state: slot k is free when o_valid[k]==0 or i_ready[k]==1 in the same cycle (pass-through refill).
- o_ready:
  - Combinational.
  - For a valid select: o_ready = ~o_valid[i_sel] | i_ready[i_sel].
  - For i_sel >= NUM_OUTPUT: o_ready = 1.
  - Does not depend on i_valid.
- Accept into channel k: slot k loads i_data and sets o_valid[k]. The slot holds data stable while o_valid[k] & ~i_ready[k].
- Drain: o_valid[k] & i_ready[k] with no new beat to k clears o_valid[k].
- Simultaneous drain and refill of k: o_valid[k] stays 1 and data updates, with no bubble.
- Channels are independent. A stall on channel j never blocks beats to k != j.
- Out-of-range select (i_sel >= NUM_OUTPUT, only possible for non-power-of-2):
  - Beat is accepted and discarded; no slot changes.
  - o_err pulses high for the cycle after acceptance.
- i_valid low: no slot loads. o_ready is still driven.
- Reset mid-operation clears all slots immediately; in-flight data is lost.

Optional Feature:
- Macro: STREAM_DEMUX_PKT_LOCK_EN.
- Enabled:
  - Two-state FSM, IDLE and LOCKED, with a locked-select register.
  - IDLE: the first accepted beat samples i_sel into the lock register and routes normally.
  - IDLE -> LOCKED when that beat has i_last==0; stays IDLE when i_last==1 (single-beat packet).
  - LOCKED: i_sel is ignored, and all beats route to the locked channel (including out-of-range drop behaviour).
  - LOCKED -> IDLE on the accepted beat with i_last==1.
  - Reset returns to IDLE.
- Disabled: i_last is unused, there is no FSM, and i_sel is used on every beat.

Decomposition:
- Package stream_demux_pkg holds:
  - lock_state_t enum: IDLE, LOCKED.
  - function sel_in_range(sel, n).
- One sub-module, stream_demux_slot: a one-entry valid/ready register (load, hold, pass-through refill). It is instantiated NUM_OUTPUT times in a generate loop.

Test Plan:
- Basic routing, NUM_OUTPUT=6, all i_ready=1: beats 0xA0..0xA5 with i_sel=0..5 -> each appears on o_data[k] one cycle later, o_valid one-hot, o_ready always 1.
- Back-pressure isolation: i_ready[2]=0, two beats to ch2 then one to ch4 -> ch2 holds the first beat stable; o_ready drops for the second ch2 beat; the ch4 beat is still blocked in order until ch2 drains (producer stalls), then flows.
- Pass-through refill: ch1 valid with i_ready[1]=1 and a new beat 0x55 to ch1 in the same cycle -> o_valid[1] stays 1 and o_data[1]=0x55 next cycle.
- Out-of-range: NUM_OUTPUT=6, i_sel=7, i_valid=1 -> o_ready=1, no o_valid change, o_err=1 for exactly one cycle.
- Reset mid-stream: assert i_rst with ch0 and ch3 holding data -> o_valid=0 and o_data=0 immediately, o_err=0.
- Packet lock (with STREAM_DEMUX_PKT_LOCK_EN): 3-beat packet, first i_sel=2, later beats i_sel=5, i_last on beat 3 -> all three beats on ch2; the next packet with i_sel=5 goes to ch5.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux valid/ready router.
// The lock-state type is used only when STREAM_DEMUX_PKT_LOCK_EN is defined.
package stream_demux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    function automatic logic sel_in_range(input int sel, input int n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry registered valid/ready slot: load, hold while stalled, refill on drain.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  free
);

    // Free either when empty or when the consumer takes the current beat this cycle.
    assign free = ~valid | ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready stream demultiplexer with one registered slot per channel.
// Define STREAM_DEMUX_PKT_LOCK_EN to hold the route for a whole packet (up to i_last).
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int NUM_OUTPUT          = 8,
    parameter int NUM_OUTPUT_BITWIDTH = $clog2(NUM_OUTPUT)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic [NUM_OUTPUT_BITWIDTH-1:0] i_sel,
    input  logic                           i_last,
    output logic [NUM_OUTPUT-1:0]          o_valid,
    input  logic [NUM_OUTPUT-1:0]          i_ready,
    output logic [DATA_WIDTH-1:0]          o_data [NUM_OUTPUT],
    output logic                           o_err
);

    localparam int SW = NUM_OUTPUT_BITWIDTH;

    logic [SW-1:0]         route_sel;
    logic                  route_ok;
    logic                  accept;
    logic [NUM_OUTPUT-1:0] slot_free;
    logic [NUM_OUTPUT-1:0] slot_load;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    lock_state_t   lock_state;
    logic [SW-1:0] lock_sel;

    assign route_sel = (lock_state == LOCKED) ? lock_sel : i_sel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_state <= IDLE;
            lock_sel   <= '0;
        end else if (accept) begin
            case (lock_state)
                IDLE: begin
                    lock_sel <= i_sel;
                    if (!i_last) lock_state <= LOCKED;
                end
                LOCKED: begin
                    if (i_last) lock_state <= IDLE;
                end
                default: lock_state <= IDLE;
            endcase
        end
    end
`else
    logic unused_last;
    assign unused_last = i_last;
    assign route_sel   = i_sel;
`endif

    assign route_ok = sel_in_range(int'(route_sel), NUM_OUTPUT);
    assign accept   = i_valid & o_ready;

    // Out-of-range selects are always accepted so the producer never wedges on them.
    always_comb begin
        o_ready   = 1'b1;
        slot_load = '0;
        for (int k = 0; k < NUM_OUTPUT; k++) begin
            if (route_sel == SW'(k)) begin
                o_ready      = slot_free[k];
                slot_load[k] = i_valid & slot_free[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= i_valid & ~route_ok;
        end
    end

    for (genvar g = 0; g < NUM_OUTPUT; g++) begin : g_slot
        stream_demux_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk      (i_clk),
            .rst      (i_rst),
            .load     (slot_load[g]),
            .load_data(i_data),
            .ready    (i_ready[g]),
            .valid    (o_valid[g]),
            .data     (o_data[g]),
            .free     (slot_free[g])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux with six channels (non-power-of-2 select).
module tb_stream_demux;

    localparam int DW = 16;
    localparam int NO = 6;
    localparam int SW = $clog2(NO);

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [SW-1:0] i_sel;
    logic          i_last;
    logic [NO-1:0] o_valid;
    logic [NO-1:0] i_ready;
    logic [DW-1:0] o_data [NO];
    logic          o_err;

    int checks;
    int errors;

    stream_demux #(
        .DATA_WIDTH(DW),
        .NUM_OUTPUT(NO)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .i_sel  (i_sel),
        .i_last (i_last),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_err  (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d,
                         input logic l);
        i_valid = v;
        i_sel   = s;
        i_data  = d;
        i_last  = l;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_ready = '1;
        drive(1'b0, '0, '0, 1'b0);
        step();
        step();
        checks++;
        if (o_valid !== 6'b000000) begin
            errors++;
            $display("FAIL reset_valid: got %b expected %b", o_valid, 6'b000000);
        end
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", o_err);
        end
        for (int k = 0; k < NO; k++) begin
            checks++;
            if (o_data[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_data%0d: got %h expected 0000", k, o_data[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_routing();
        i_ready = '1;
        for (int k = 0; k < NO; k++) begin
            drive(1'b1, SW'(k), DW'(16'h00A0 + k), 1'b1);
            #1;
            checks++;
            if (o_ready !== 1'b1) begin
                errors++;
                $display("FAIL route_ready%0d: got %b expected 1", k, o_ready);
            end
            step();
            checks++;
            if (o_valid !== NO'(1 << k)) begin
                errors++;
                $display("FAIL route_valid%0d: got %b expected %b", k, o_valid, NO'(1 << k));
            end
            checks++;
            if (o_data[k] !== DW'(16'h00A0 + k)) begin
                errors++;
                $display("FAIL route_data%0d: got %h expected %h", k, o_data[k], 16'h00A0 + k);
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
        checks++;
        if (o_valid !== 6'b000000) begin
            errors++;
            $display("FAIL route_drain: got %b expected 000000", o_valid);
        end
    endtask

    task automatic test_backpressure();
        i_ready = 6'b111011;
        drive(1'b1, 3'd2, 16'h0021, 1'b1);
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_first: got %b expected 1", o_ready);
        end
        step();
        drive(1'b1, 3'd2, 16'h0022, 1'b1);
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_second: got %b expected 0", o_ready);
        end
        step();
        step();
        checks++;
        if (o_valid !== 6'b000100 || o_data[2] !== 16'h0021) begin
            errors++;
            $display("FAIL bp_hold: got valid %b data %h expected 000100 0021", o_valid, o_data[2]);
        end
        i_ready = '1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", o_ready);
        end
        step();
        checks++;
        if (o_valid !== 6'b000100 || o_data[2] !== 16'h0022) begin
            errors++;
            $display("FAIL bp_second: got valid %b data %h expected 000100 0022", o_valid, o_data[2]);
        end
        drive(1'b1, 3'd4, 16'h0044, 1'b1);
        step();
        checks++;
        if (o_valid !== 6'b010000 || o_data[4] !== 16'h0044) begin
            errors++;
            $display("FAIL bp_ch4: got valid %b data %h expected 010000 0044", o_valid, o_data[4]);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_refill();
        i_ready = '1;
        drive(1'b1, 3'd1, 16'h0011, 1'b1);
        step();
        checks++;
        if (o_valid !== 6'b000010 || o_data[1] !== 16'h0011) begin
            errors++;
            $display("FAIL refill_first: got valid %b data %h expected 000010 0011", o_valid, o_data[1]);
        end
        drive(1'b1, 3'd1, 16'h0055, 1'b1);
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL refill_ready: got %b expected 1", o_ready);
        end
        step();
        checks++;
        if (o_valid !== 6'b000010 || o_data[1] !== 16'h0055) begin
            errors++;
            $display("FAIL refill_second: got valid %b data %h expected 000010 0055", o_valid, o_data[1]);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_out_of_range();
        i_ready = 6'b110111;
        drive(1'b1, 3'd3, 16'h0033, 1'b1);
        step();
        drive(1'b1, 3'd7, 16'h00EE, 1'b1);
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL oor_ready: got %b expected 1", o_ready);
        end
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_before: got %b expected 0", o_err);
        end
        step();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_pulse: got %b expected 1", o_err);
        end
        checks++;
        if (o_valid !== 6'b001000 || o_data[3] !== 16'h0033) begin
            errors++;
            $display("FAIL oor_slots: got valid %b data %h expected 001000 0033", o_valid, o_data[3]);
        end
        step();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_clear: got %b expected 0", o_err);
        end
        i_ready = '1;
        step();
    endtask

    task automatic test_reset_mid();
        i_ready = '0;
        drive(1'b1, 3'd0, 16'h000A, 1'b1);
        step();
        drive(1'b1, 3'd3, 16'h003C, 1'b1);
        step();
        drive(1'b1, 3'd6, 16'h00FF, 1'b1);
        checks++;
        if (o_valid !== 6'b001001) begin
            errors++;
            $display("FAIL rstmid_pre: got %b expected 001001", o_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 6'b000000 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got valid %b err %b expected 000000 0", o_valid, o_err);
        end
        checks++;
        if (o_data[0] !== 16'h0000 || o_data[3] !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_data: got %h %h expected 0000 0000", o_data[0], o_data[3]);
        end
        drive(1'b0, '0, '0, 1'b0);
        i_ready = '1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_pkt_route();
        i_ready = '1;
`ifdef STREAM_DEMUX_PKT_LOCK_EN
        drive(1'b1, 3'd2, 16'h00B1, 1'b0);
        step();
        checks++;
        if (o_valid !== 6'b000100 || o_data[2] !== 16'h00B1) begin
            errors++;
            $display("FAIL lock_b1: got valid %b data %h expected 000100 00B1", o_valid, o_data[2]);
        end
        drive(1'b1, 3'd5, 16'h00B2, 1'b0);
        step();
        checks++;
        if (o_valid !== 6'b000100 || o_data[2] !== 16'h00B2) begin
            errors++;
            $display("FAIL lock_b2: got valid %b data %h expected 000100 00B2", o_valid, o_data[2]);
        end
        drive(1'b1, 3'd5, 16'h00B3, 1'b1);
        step();
        checks++;
        if (o_valid !== 6'b000100 || o_data[2] !== 16'h00B3) begin
            errors++;
            $display("FAIL lock_b3: got valid %b data %h expected 000100 00B3", o_valid, o_data[2]);
        end
        drive(1'b1, 3'd5, 16'h00C1, 1'b1);
        step();
        checks++;
        if (o_valid !== 6'b100000 || o_data[5] !== 16'h00C1) begin
            errors++;
            $display("FAIL lock_next: got valid %b data %h expected 100000 00C1", o_valid, o_data[5]);
        end
`else
        drive(1'b1, 3'd2, 16'h00B1, 1'b0);
        step();
        checks++;
        if (o_valid !== 6'b000100 || o_data[2] !== 16'h00B1) begin
            errors++;
            $display("FAIL nolock_b1: got valid %b data %h expected 000100 00B1", o_valid, o_data[2]);
        end
        drive(1'b1, 3'd5, 16'h00B2, 1'b0);
        step();
        checks++;
        if (o_valid !== 6'b100000 || o_data[5] !== 16'h00B2) begin
            errors++;
            $display("FAIL nolock_b2: got valid %b data %h expected 100000 00B2", o_valid, o_data[5]);
        end
`endif
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_routing();
        test_backpressure();
        test_refill();
        test_out_of_range();
        test_reset_mid();
        test_pkt_route();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
